// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//
// Command-driven sequencer for a bank of N JK flip-flops. Commands (HOLD,
// RESET, SET, TOGGLE) enter through a valid/ready port into a small FIFO.
// Each command is popped, its target Q is sampled, the addressed flip-flop's
// J/K pair is driven for the requested number of cycles, and the resulting
// Q is checked against the value the operation should have produced.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present on cmd_op/cmd_idx/cmd_len
//   cmd_ready  FIFO can accept a command (not full)
//   cmd_op     0=HOLD, 1=RESET, 2=SET, 3=TOGGLE
//   cmd_idx    target flip-flop index
//   cmd_len    number of drive cycles (0 behaves as 1)
//   j_out      J inputs to the bank (only the addressed bit, only in DRIVE)
//   k_out      K inputs to the bank (only the addressed bit, only in DRIVE)
//   q_in       Q outputs from the bank
//   busy       sequencer active or FIFO non-empty
//   done       one-cycle pulse when a command completes
//   err        one-cycle pulse with done on Q check failure or bad index

module jk_bank_sequencer #(
    parameter int unsigned N          = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [N-1:0]     j_out,
    output logic [N-1:0]     k_out,
    input  logic [N-1:0]     q_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENT_W = 2 + IDX_W + CNT_W;

    localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
    localparam logic [PTR_W:0]   CountOne = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FifoFull = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    localparam logic [1:0] OpHold   = 2'd0;
    localparam logic [1:0] OpReset  = 2'd1;
    localparam logic [1:0] OpSet    = 2'd2;
    localparam logic [1:0] OpToggle = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrive,
        StCheck
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_remaining;
    logic             r_q_start;
    logic             r_bad;

    logic             w_idx_ok;
    logic             w_q_sel;
    logic             w_len_odd;
    logic             w_expect;

    assign w_full    = (r_count == FifoFull);
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == StIdle) && !w_empty;
    assign w_head    = r_mem[r_rd_ptr];
    assign cmd_ready = !w_full;
    assign busy      = (r_state != StIdle) || !w_empty;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_idx, cmd_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + CountOne;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CountOne;
            end
        end
    end

    // ------------------------------------------------------------------
    // Index decode: an index outside the bank selects nothing and reads 0,
    // so an oversized IDX_W never indexes past q_in.
    // ------------------------------------------------------------------
    always_comb begin
        w_idx_ok = 1'b0;
        w_q_sel  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(r_idx) == i) begin
                w_idx_ok = 1'b1;
                w_q_sel  = q_in[i];
            end
        end
    end

    // A zero length runs one cycle, so its toggle parity is odd.
    assign w_len_odd = (r_len == '0) ? 1'b1 : r_len[0];

    always_comb begin
        w_expect = r_q_start;
        unique case (r_op)
            OpHold:   w_expect = r_q_start;
            OpReset:  w_expect = 1'b0;
            OpSet:    w_expect = 1'b1;
            OpToggle: w_expect = r_q_start ^ w_len_odd;
            default:  w_expect = r_q_start;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_state_next = w_idx_ok ? StDrive : StCheck;
            end
            StDrive: begin
                if (r_remaining == CntOne) begin
                    w_state_next = StCheck;
                end
            end
            StCheck: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        j_out = '0;
        k_out = '0;
        done  = 1'b0;
        err   = 1'b0;
        if (r_state == StDrive) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(r_idx) == i) begin
                    j_out[i] = (r_op == OpSet)   || (r_op == OpToggle);
                    k_out[i] = (r_op == OpReset) || (r_op == OpToggle);
                end
            end
        end
        if (r_state == StCheck) begin
            done = 1'b1;
            err  = r_bad || (w_q_sel != w_expect);
        end
    end

    // ------------------------------------------------------------------
    // State and command registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op        <= OpHold;
            r_idx       <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_q_start   <= 1'b0;
            r_bad       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                {r_op, r_idx, r_len} <= w_head;
            end
            unique case (r_state)
                StLoad: begin
                    r_q_start   <= w_q_sel;
                    r_remaining <= (r_len == '0) ? CntOne : r_len;
                    r_bad       <= !w_idx_ok;
                end
                StDrive: begin
                    r_remaining <= r_remaining - CntOne;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer
//
// Bench for jk_bank_sequencer. A JK bank model feeds q_in from j_out/k_out.
// A transaction-level reference (queue of accepted commands plus a cycle
// offset into the active command) predicts every output each cycle; directed
// tests add hand-computed literal expectations. A second instance with N=6,
// IDX_W=3 covers the out-of-range index.

module tb_jk_bank_sequencer;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_RST  = 2'd1;
    localparam logic [1:0] OP_SET  = 2'd2;
    localparam logic [1:0] OP_TOG  = 2'd3;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] idx;
        logic [3:0] len;
    } cmd_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op  = '0;
    logic [1:0] cmd_idx = '0;
    logic [3:0] cmd_len = '0;
    logic       cmd_ready;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic [3:0] q_in;
    logic       busy;
    logic       done;
    logic       err;

    logic       cmd_valid6 = 1'b0;
    logic [1:0] cmd_op6  = '0;
    logic [2:0] cmd_idx6 = '0;
    logic [3:0] cmd_len6 = '0;
    logic       cmd_ready6;
    logic [5:0] j6;
    logic [5:0] k6;
    logic [5:0] q6 = '0;
    logic       busy6;
    logic       done6;
    logic       err6;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.N(4), .IDX_W(2), .CNT_W(4), .FIFO_DEPTH(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_idx  (cmd_idx),
        .cmd_len  (cmd_len),
        .j_out    (j_out),
        .k_out    (k_out),
        .q_in     (q_in),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    jk_bank_sequencer #(.N(6), .IDX_W(3), .CNT_W(4), .FIFO_DEPTH(4)) u_dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid6),
        .cmd_ready(cmd_ready6),
        .cmd_op   (cmd_op6),
        .cmd_idx  (cmd_idx6),
        .cmd_len  (cmd_len6),
        .j_out    (j6),
        .k_out    (k6),
        .q_in     (q6),
        .busy     (busy6),
        .done     (done6),
        .err      (err6)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // JK bank; stuck0 forces selected Q outputs low without touching the cells.
    logic [3:0] bank_q = 4'b0000;
    logic [3:0] stuck0 = 4'b0000;
    assign q_in = bank_q & ~stuck0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            case ({j_out[i], k_out[i]})
                2'b01:   bank_q[i] <= 1'b0;
                2'b10:   bank_q[i] <= 1'b1;
                2'b11:   bank_q[i] <= ~bank_q[i];
                default: bank_q[i] <= bank_q[i];
            endcase
        end
    end

    // Reference: accepted commands wait in m_fifo; the active one is m_cur and
    // m_t counts cycles since it was popped (0 = load, 1..L = drive, L+1 = check).
    cmd_t m_fifo[$];
    cmd_t m_cur  = '0;
    bit   m_act  = 1'b0;
    int   m_t    = 0;
    logic m_qs   = 1'b0;
    bit   m_acc  = 1'b0;

    function automatic int eff_len(input cmd_t c);
        return (c.len == 4'd0) ? 1 : int'(c.len);
    endfunction

    function automatic bit idx_bad(input cmd_t c);
        return int'(c.idx) >= N;
    endfunction

    function automatic int drv_len(input cmd_t c);
        return idx_bad(c) ? 0 : eff_len(c);
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_fifo.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            m_acc = cmd_valid && (m_fifo.size() < DEPTH);
            if (m_act) begin
                if (m_t == drv_len(m_cur) + 1) m_act = 1'b0;
                else m_t = m_t + 1;
            end else if (m_fifo.size() != 0) begin
                m_cur = m_fifo.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end
            if (m_acc) m_fifo.push_back({cmd_op, cmd_idx, cmd_len});
        end
    end

    // Monitors and per-cycle comparison
    logic [3:0] ej, ek, pat_j, pat_k;
    logic       ed, ee, eb, er, qx;
    int         dl;
    int         pat_hits = 0, drv_cycles = 0, done_cnt = 0, last_done_cyc = 0;
    logic       last_err = 1'b0;
    int         drive6 = 0, done6_cnt = 0, done6_cyc = 0;
    logic       err6_last = 1'b0;

    always begin
        @(negedge clk);
        ej = '0; ek = '0; ed = 1'b0; ee = 1'b0; qx = 1'b0;
        if (m_act) begin
            dl = drv_len(m_cur);
            if (m_t == 0) m_qs = q_in[m_cur.idx];
            if (m_t >= 1 && m_t <= dl) begin
                ej[m_cur.idx] = (m_cur.op == OP_SET) || (m_cur.op == OP_TOG);
                ek[m_cur.idx] = (m_cur.op == OP_RST) || (m_cur.op == OP_TOG);
            end
            if (m_t == dl + 1) begin
                ed = 1'b1;
                case (m_cur.op)
                    OP_HOLD: qx = m_qs;
                    OP_RST:  qx = 1'b0;
                    OP_SET:  qx = 1'b1;
                    default: qx = m_qs ^ (eff_len(m_cur) % 2 == 1);
                endcase
                ee = idx_bad(m_cur) || (q_in[m_cur.idx] !== qx);
            end
        end
        eb = m_act || (m_fifo.size() != 0);
        er = m_fifo.size() < DEPTH;
        check("j_out", 32'(j_out), 32'(ej));
        check("k_out", 32'(k_out), 32'(ek));
        check("done", 32'(done), 32'(ed));
        check("err", 32'(err), 32'(ee));
        check("busy", 32'(busy), 32'(eb));
        check("cmd_ready", 32'(cmd_ready), 32'(er));
        if (j_out == pat_j && k_out == pat_k) pat_hits++;
        if (j_out != 0 || k_out != 0) drv_cycles++;
        if (done) begin
            done_cnt++;
            last_err = err;
            last_done_cyc = cyc;
        end
        if (j6 != 0 || k6 != 0) drive6++;
        if (done6) begin
            done6_cnt++;
            err6_last = err6;
            done6_cyc = cyc;
        end
    end

    task automatic clear_mon(input logic [3:0] pj, input logic [3:0] pk);
        @(posedge clk);
        #1;
        pat_j = pj; pat_k = pk;
        pat_hits = 0; drv_cycles = 0; done_cnt = 0;
        drive6 = 0; done6_cnt = 0;
    endtask

    int acc_cyc = 0;

    task automatic push(input logic [1:0] op, input logic [1:0] idx, input logic [3:0] len);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_len = len;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    cmd_t burst[5];
    int   k_acc, n, base, acc6;
    bit   saw_full, will;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        pat_j = '0; pat_k = '0;
        burst[0] = {OP_SET,  2'd0, 4'd1};
        burst[1] = {OP_SET,  2'd1, 4'd2};
        burst[2] = {OP_TOG,  2'd3, 4'd1};
        burst[3] = {OP_RST,  2'd0, 4'd2};
        burst[4] = {OP_HOLD, 2'd2, 4'd1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_j", 32'(j_out), 32'd0);
        check("rst_k", 32'(k_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // SET idx2 len1
        clear_mon(4'b0100, 4'b0000);
        push(OP_SET, 2'd2, 4'd1);
        wait_done(1, 20, "set_done_timeout");
        check("set_latency", 32'(last_done_cyc - acc_cyc), 32'd3);
        check("set_j_cycles", 32'(pat_hits), 32'd1);
        check("set_drive_cycles", 32'(drv_cycles), 32'd1);
        check("set_err", 32'(last_err), 32'd0);
        check("set_q", 32'(q_in), 32'b0100);

        // RESET idx2 len0 runs one cycle
        clear_mon(4'b0000, 4'b0100);
        push(OP_RST, 2'd2, 4'd0);
        wait_done(1, 20, "rst_done_timeout");
        check("reset_k_cycles", 32'(pat_hits), 32'd1);
        check("reset_err", 32'(last_err), 32'd0);
        check("reset_q", 32'(q_in), 32'b0000);

        // TOGGLE idx1 len3
        clear_mon(4'b0010, 4'b0010);
        push(OP_TOG, 2'd1, 4'd3);
        wait_done(1, 20, "tog_done_timeout");
        check("tog_jk_cycles", 32'(pat_hits), 32'd3);
        check("tog_err", 32'(last_err), 32'd0);
        check("tog_q", 32'(q_in), 32'b0010);

        // Same toggle with q[1] stuck low
        stuck0 = 4'b0010;
        clear_mon(4'b0010, 4'b0010);
        push(OP_TOG, 2'd1, 4'd3);
        wait_done(1, 20, "stuck_done_timeout");
        check("stuck_err", 32'(last_err), 32'd1);
        stuck0 = 4'b0000;

        // Long HOLD stalls the sequencer while five commands are pushed
        clear_mon(4'b1111, 4'b1111);
        push(OP_HOLD, 2'd0, 4'd15);
        @(negedge clk);
        k_acc = 0; saw_full = 1'b0; n = 0;
        cmd_valid = 1'b1;
        {cmd_op, cmd_idx, cmd_len} = burst[0];
        while (k_acc < 5 && n < 200) begin
            if (!cmd_ready && !saw_full) begin
                saw_full = 1'b1;
                check("accepted_before_full", 32'(k_acc), 32'd4);
            end
            will = cmd_ready;
            @(negedge clk);
            n++;
            if (will) begin
                k_acc++;
                if (k_acc < 5) {cmd_op, cmd_idx, cmd_len} = burst[k_acc];
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("burst_accepted", 32'(k_acc), 32'd5);
        check("burst_saw_full", 32'(saw_full), 32'd1);
        // stall command plus five burst commands
        wait_done(6, 300, "burst_done_timeout");
        repeat (5) @(negedge clk);
        #1;
        check("burst_done_pulses", 32'(done_cnt), 32'd6);
        check("burst_q", 32'(q_in), 32'b1010);
        check("burst_idle", 32'(busy), 32'd0);

        // HOLD idx3 len2
        clear_mon(4'b1111, 4'b1111);
        push(OP_HOLD, 2'd3, 4'd2);
        wait_done(1, 20, "hold_done_timeout");
        check("hold_drive_cycles", 32'(drv_cycles), 32'd0);
        check("hold_err", 32'(last_err), 32'd0);
        check("hold_q", 32'(q_in), 32'b1010);

        // Out-of-range index on the six-wide instance
        clear_mon(4'b1111, 4'b1111);
        @(negedge clk);
        check("dut6_ready", 32'(cmd_ready6), 32'd1);
        cmd_valid6 = 1'b1; cmd_op6 = OP_SET; cmd_idx6 = 3'd7; cmd_len6 = 4'd3;
        @(posedge clk);
        #1;
        acc6 = cyc;
        @(negedge clk);
        cmd_valid6 = 1'b0;
        n = 0;
        while (done6_cnt == 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("bad_idx_done", 32'(done6_cnt), 32'd1);
        check("bad_idx_err", 32'(err6_last), 32'd1);
        check("bad_idx_drive", 32'(drive6), 32'd0);
        check("bad_idx_latency", 32'(done6_cyc - acc6), 32'd2);

        // Asynchronous reset in the middle of a long TOGGLE
        clear_mon(4'b0001, 4'b0001);
        push(OP_TOG, 2'd0, 4'd8);
        n = 0;
        while (j_out == 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_drive_seen", 32'(j_out), 32'b0001);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_j", 32'(j_out), 32'd0);
        check("rst_mid_k", 32'(k_out), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        repeat (15) @(negedge clk);
        #1;
        check("post_rst_no_done", 32'(done_cnt), 32'(base));
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Command-driven controller that sequences a bank of N JK flip-flops through their J/K inputs and reads back their Q outputs. Requesters push HOLD/RESET/SET/TOGGLE commands through a valid/ready port into a small FIFO. The sequencer pops commands one at a time, drives J/K for the addressed flip-flop for a programmable number of cycles, and then checks the resulting Q. It sits between control logic and the JK flip-flop bank, and is the only driver of the bank's J/K inputs.

Parameters:
N, 4, number of JK flip-flops in the bank (≥2)
IDX_W, 2, index width, equal to clog2(N)
CNT_W, 4, width of the repeat-length field
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_op  input  2  0=HOLD, 1=RESET, 2=SET, 3=TOGGLE
cmd_idx  input  IDX_W  target flip-flop index
cmd_len  input  CNT_W  number of drive cycles; 0 is treated as 1
j_out  output  N  J inputs to the bank
k_out  output  N  K inputs to the bank
q_in  input  N  Q outputs from the bank
busy  output  1  high whenever state != IDLE or the FIFO is non-empty
done  output  1  one-cycle pulse when a command completes
err  output  1  one-cycle pulse coincident with done on a check failure or a bad index

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO is emptied and the state is IDLE.
  - j_out=0, k_out=0, done=0, err=0, busy=0, cmd_ready=1.
  - Reset takes effect immediately, including mid-DRIVE.
- Handshake:
  - A push occurs on the edge where cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
  - When the FIFO is full, cmd_ready=0 and the input is ignored; there is no overwrite.
- FSM states: IDLE, LOAD, DRIVE, CHECK.
  - IDLE: if the FIFO is non-empty, pop at the next edge, latch op/idx/len, and go to LOAD. Otherwise stay in IDLE.
  - LOAD (1 cycle):
    - Capture q_in[idx] as q_start.
    - Set remaining = (len==0 ? 1 : len).
    - If idx ≥ N, go to CHECK with a bad-index flag and no drive. Otherwise go to DRIVE.
  - DRIVE (remaining cycles):
    - Only bit idx of j_out/k_out is driven; all other bits are 0.
    - Drive values by op: HOLD j=0 k=0; RESET j=0 k=1; SET j=1 k=0; TOGGLE j=1 k=1.
    - remaining decrements each cycle. Go to CHECK after the cycle in which remaining==1.
  - CHECK (1 cycle):
    - j_out=k_out=0 and done=1.
    - Expected Q value: SET gives 1; RESET gives 0; HOLD gives q_start; TOGGLE gives q_start XOR (effective len mod 2).
    - err=1 if q_in[idx] != expected or on bad index.
    - Next state is IDLE.
- Latency: for a command accepted at edge E0 into an empty, idle block:
  - LOAD in the cycle after E1.
  - DRIVE from E2 for L cycles.
  - done in the cycle after edge E2+L.
- j_out/k_out are decoded only from registered state. They are all-zero in IDLE, LOAD and CHECK.
- Back-to-back commands: there is a minimum of one IDLE cycle between CHECK and the next LOAD.
- The bank is assumed to update Q on the same clk edge that ends each DRIVE cycle.

Test Plan:
- Reset, then push SET idx=2 len=1 with q_in tracking a bench JK model starting at 0 → j_out=4'b0100, k_out=0 for exactly 1 cycle; done=1, err=0 on the 3rd edge after acceptance; q[2]=1.
- From q=4'b0100, push RESET idx=2 len=0 → k_out=4'b0100 for 1 cycle (len 0 treated as 1); q[2]=0; done=1, err=0.
- TOGGLE idx=1 len=3 from q[1]=0 → j_out=k_out=4'b0010 for 3 consecutive cycles; final q[1]=1; err=0. Repeat with the bench model forcing q[1] stuck at 0 → err=1 with done.
- Push 5 commands back-to-back with cmd_valid held high while the sequencer is stalled → cmd_ready drops after 4 accepted (FIFO full). The 5th command is accepted once the first pop occurs. All 5 complete in order, and exactly 5 done pulses are seen.
- HOLD idx=3 len=2 → j_out=k_out=0 throughout; done=1, err=0, q unchanged. Use N=6, IDX_W=3, cmd_idx=7 → no J/K activity; done=1, err=1.
- Assert rst_n=0 mid-DRIVE of TOGGLE len=8 → j_out/k_out=0 and busy=0 immediately. After release, the FIFO is empty, cmd_ready=1, and no done pulse occurs.
